// File: rtl/spi_slave_mem.sv
// rtl/spi_slave_mem.sv - SPI mode-0 slave giving read/write access to a small register file
module spi_slave_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int MEM_DEPTH  = 16
) (
    input  logic                  pclk_i,
    input  logic                  prst_i,
    input  logic                  sclk_i,
    input  logic                  ssel_i,
    input  logic                  mosi_i,
    output logic                  miso_o,
    output logic                  wr_valid_o,
    output logic [6:0]            wr_addr_o,
    output logic [DATA_WIDTH-1:0] wr_data_o,
    output logic                  frame_err_o
);

    localparam int MAXW = (DATA_WIDTH > 8) ? DATA_WIDTH : 8;
    localparam int CW   = $clog2(MAXW) + 1;
    localparam int AW   = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, CMD, DATA, HOLD} state_t;

    logic [1:0]            sclk_ff, ssel_ff, mosi_ff;
    logic                  sclk_d, ssel_d;
    logic                  sclk_s, ssel_s, mosi_s;
    logic                  sclk_rise, sclk_fall, ssel_fall;
    state_t                state_q, state_d;
    logic [CW-1:0]         bit_cnt;
    logic [7:0]            cmd_sr, cmd_q, cmd_next;
    logic [DATA_WIDTH-1:0] rx_sr, tx_sr, rx_next, rd_word;
    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
    logic                  cmd_last, data_last, abort;
    logic                  next_in_range, cur_in_range;

    assign sclk_s    = sclk_ff[1];
    assign ssel_s    = ssel_ff[1];
    assign mosi_s    = mosi_ff[1];
    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;
    assign ssel_fall = ~ssel_s & ssel_d;

    assign cmd_next      = (cmd_sr << 1) | {7'd0, mosi_s};
    assign rx_next       = (rx_sr << 1) | DATA_WIDTH'(mosi_s);
    assign next_in_range = {1'b0, cmd_next[6:0]} < 8'(MEM_DEPTH);
    assign cur_in_range  = {1'b0, cmd_q[6:0]} < 8'(MEM_DEPTH);
    // Read data is fetched as the command completes so the MSB is ready for the first falling edge.
    assign rd_word       = (!cmd_next[7] && next_in_range) ? mem[cmd_next[AW-1:0]] : '0;
    assign cmd_last      = sclk_rise && (bit_cnt == CW'(7));
    assign data_last     = sclk_rise && (bit_cnt == CW'(DATA_WIDTH - 1));

    always_ff @(posedge pclk_i or negedge prst_i) begin
        if (!prst_i) begin
            sclk_ff <= 2'b00;
            ssel_ff <= 2'b11;
            mosi_ff <= 2'b00;
            sclk_d  <= 1'b0;
            ssel_d  <= 1'b1;
        end else begin
            sclk_ff <= {sclk_ff[0], sclk_i};
            ssel_ff <= {ssel_ff[0], ssel_i};
            mosi_ff <= {mosi_ff[0], mosi_i};
            sclk_d  <= sclk_s;
            ssel_d  <= ssel_s;
        end
    end

    always_ff @(posedge pclk_i or negedge prst_i) begin
        if (!prst_i) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // A deselect always wins; IDLE ignores sclk, so an sclk edge coinciding with the select edge is dropped.
    always_comb begin
        state_d = state_q;
        abort   = 1'b0;
        if (ssel_s) begin
            state_d = IDLE;
            abort   = (state_q == CMD) || (state_q == DATA);
        end else begin
            case (state_q)
                IDLE:    if (ssel_fall) state_d = CMD;
                CMD:     if (cmd_last)  state_d = DATA;
                DATA:    if (data_last) state_d = HOLD;
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge pclk_i or negedge prst_i) begin
        if (!prst_i) begin
            bit_cnt     <= '0;
            cmd_sr      <= '0;
            cmd_q       <= '0;
            rx_sr       <= '0;
            tx_sr       <= '0;
            miso_o      <= 1'b0;
            wr_valid_o  <= 1'b0;
            wr_addr_o   <= '0;
            wr_data_o   <= '0;
            frame_err_o <= 1'b0;
            for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
        end else begin
            wr_valid_o  <= 1'b0;
            frame_err_o <= abort;
            if (ssel_s) begin
                miso_o  <= 1'b0;
                bit_cnt <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (ssel_fall) begin
                            bit_cnt <= '0;
                            cmd_sr  <= '0;
                        end
                    end
                    CMD: begin
                        miso_o <= 1'b0;
                        if (sclk_rise) begin
                            cmd_sr <= cmd_next;
                            if (cmd_last) begin
                                cmd_q   <= cmd_next;
                                bit_cnt <= '0;
                                tx_sr   <= rd_word;
                                rx_sr   <= '0;
                            end else begin
                                bit_cnt <= bit_cnt + CW'(1);
                            end
                        end
                    end
                    DATA: begin
                        if (sclk_fall) begin
                            miso_o <= tx_sr[DATA_WIDTH-1];
                            tx_sr  <= tx_sr << 1;
                        end
                        if (sclk_rise) begin
                            rx_sr   <= rx_next;
                            bit_cnt <= bit_cnt + CW'(1);
                            if (data_last && cmd_q[7] && cur_in_range) begin
                                mem[cmd_q[AW-1:0]] <= rx_next;
                                wr_valid_o         <= 1'b1;
                                wr_addr_o          <= cmd_q[6:0];
                                wr_data_o          <= rx_next;
                            end
                        end
                    end
                    HOLD: miso_o <= 1'b0;
                endcase
            end
        end
    end

endmodule
